// File: rtl/jtexterm_romslot.sv
// Graphics ROM slot responder: 2-entry word cache in front of the shared SDRAM controller.
// Optional hit/miss counters are built when JTEXTERM_ROMSLOT_STATS_EN is defined.
module jtexterm_romslot #(
    parameter int              AW     = 20,
    parameter int              SDW    = 22,
    parameter logic [SDW-1:0]  OFFSET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slot_cs,
    input  logic [AW-1:0]   slot_addr,
    output logic [31:0]     slot_dout,
    output logic            slot_ok,
    output logic            sdram_req,
    output logic [SDW-1:0]  sdram_addr,
    input  logic            sdram_ack,
    input  logic            sdram_dst,
    input  logic            sdram_rdy,
    input  logic [31:0]     sdram_din
`ifdef JTEXTERM_ROMSLOT_STATS_EN
    ,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     miss_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam int SW = (SDW > AW + 1) ? SDW : AW + 1;

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_valid;
    logic [AW-1:0]    r_tag  [2];
    logic [31:0]      r_data [2];
    logic             r_ptr;
    logic [AW-1:0]    r_reqAddr;

    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic [31:0]      w_hitData;
    logic             w_issue;
    logic             w_fill;
    logic             w_dropReq;
    logic [SW-1:0]    w_sum;
    logic [SDW-1:0]   w_sdAddr;

    // Entry 0 has priority if both tags ever matched
    assign w_hit0    = slot_cs & r_valid[0] & (r_tag[0] == slot_addr);
    assign w_hit1    = slot_cs & r_valid[1] & (r_tag[1] == slot_addr);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hitData = w_hit0 ? r_data[0] : r_data[1];

    // Word address to halfword address; the region base wraps around the SDRAM size
    assign w_sum    = SW'(OFFSET) + SW'({slot_addr, 1'b0});
    assign w_sdAddr = w_sum[SDW-1:0];

    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_fill      = 1'b0;
        w_dropReq   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (slot_cs && !w_hit) begin
                    w_issue     = 1'b1;
                    w_nextState = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sdram_ack) begin
                    w_dropReq = 1'b1;
                    if (sdram_rdy && sdram_dst) begin
                        w_fill      = 1'b1;
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextState = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (sdram_rdy && sdram_dst) begin
                    w_fill      = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            r_reqAddr  <= '0;
        end else begin
            if (w_issue) begin
                sdram_req  <= 1'b1;
                sdram_addr <= w_sdAddr;
                r_reqAddr  <= slot_addr;
            end else if (w_dropReq) begin
                sdram_req  <= 1'b0;
            end
        end
    end

    // A fetch always completes into the cache, even if the requester moved on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_fill) begin
            r_valid[r_ptr] <= 1'b1;
            r_tag[r_ptr]   <= r_reqAddr;
            r_data[r_ptr]  <= sdram_din;
            r_ptr          <= ~r_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_ok   <= 1'b0;
            slot_dout <= '0;
        end else if (w_hit) begin
            slot_ok   <= 1'b1;
            slot_dout <= w_hitData;
        end else begin
            slot_ok   <= 1'b0;
        end
    end

`ifdef JTEXTERM_ROMSLOT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_hit && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (w_issue && miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtexterm_romslot.sv
// Directed bench for jtexterm_romslot: cache hits, misses, replacement, mid-fetch changes and reset.
// A second instance with a high OFFSET checks address wrap-around.
module tb_jtexterm_romslot;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slot_cs = 1'b0;
    logic [19:0] slot_addr = '0;
    logic        sdram_ack = 1'b0;
    logic        sdram_dst = 1'b0;
    logic        sdram_rdy = 1'b0;
    logic [31:0] sdram_din = '0;

    logic [31:0] slot_dout;
    logic        slot_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [31:0] slot_dout2;
    logic        slot_ok2;
    logic        sdram_req2;
    logic [21:0] sdram_addr2;
`ifdef JTEXTERM_ROMSLOT_STATS_EN
    logic [15:0] hit_cnt, miss_cnt, hit_cnt2, miss_cnt2;
`endif

    int total = 0;
    int bad = 0;
    int expHits = 0;
    int expMiss = 0;

    always #5 clk = ~clk;

    jtexterm_romslot #(.AW(20), .SDW(22), .OFFSET(22'h0)) dut (
        .clk(clk), .rst(rst), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(slot_dout), .slot_ok(slot_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
`ifdef JTEXTERM_ROMSLOT_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    jtexterm_romslot #(.AW(20), .SDW(22), .OFFSET(22'h3FFFF0)) dutWrap (
        .clk(clk), .rst(rst), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(slot_dout2), .slot_ok(slot_ok2),
        .sdram_req(sdram_req2), .sdram_addr(sdram_addr2),
        .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
        .sdram_rdy(sdram_rdy), .sdram_din(sdram_din)
`ifdef JTEXTERM_ROMSLOT_STATS_EN
        , .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
`endif
    );

    typedef struct {
        logic        cs;
        logic [19:0] addr;
        logic        expOk;
        logic [31:0] expDout;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic [19:0] a, input logic ack,
                                 input logic rdy, input logic dst, input logic [31:0] din);
        slot_cs   = cs;
        slot_addr = a;
        sdram_ack = ack;
        sdram_rdy = rdy;
        sdram_dst = dst;
        sdram_din = din;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOk(input string name, input logic expOk);
        checkOutput(name, 32'(slot_ok), 32'(expOk));
        if (expOk) expHits++;
    endtask

    // Full miss sequence for one address: request, ack, data, then a hit
    task automatic doFetch(input logic [19:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("fetch_req", 32'(sdram_req), 32'd1);
        checkOutput("fetch_addr", 32'(sdram_addr), 32'({a, 1'b0}));
        checkOk("fetch_ok_miss", 1'b0);
        expMiss++;
        applyStimulus(1'b1, a, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("fetch_req_drop", 32'(sdram_req), 32'd0);
        applyStimulus(1'b1, a, 1'b0, 1'b1, 1'b1, d);
        tick();
        checkOk("fetch_ok_fill", 1'b0);
        applyStimulus(1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("fetch_ok_hit", 1'b1);
        checkOutput("fetch_dout", slot_dout, d);
        checkOutput("fetch_no_req", 32'(sdram_req), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 20'h10, 1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 20'h11, 1'b1, 32'hCAFE0011};
        vecs[2] = '{1'b1, 20'h10, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 20'h10, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 20'h11, 1'b1, 32'hCAFE0011};
        vecs[5] = '{1'b0, 20'h11, 1'b0, 32'hCAFE0011};
        vecs[6] = '{1'b0, 20'h10, 1'b0, 32'hCAFE0011};
        vecs[7] = '{1'b1, 20'h10, 1'b1, 32'hDEADBEEF};

        // Reset state
        applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        repeat (3) tick();
        checkOk("rst_ok", 1'b0);
        checkOutput("rst_dout", slot_dout, 32'h0);
        checkOutput("rst_req", 32'(sdram_req), 32'd0);
        checkOutput("rst_addr", 32'(sdram_addr), 32'h0);
        rst = 1'b0;
        tick();

        // First miss, request held until ack, stray rdy for another slot ignored
        applyStimulus(1'b1, 20'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        expMiss++;
        checkOutput("s1_req", 32'(sdram_req), 32'd1);
        checkOutput("s1_addr", 32'(sdram_addr), 32'h20);
        checkOutput("wrap_addr", 32'(sdram_addr2), 32'h10);
        checkOk("s1_ok_miss", 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("s1_req_hold", 32'(sdram_req), 32'd1);
            checkOutput("s1_addr_hold", 32'(sdram_addr), 32'h20);
        end
        applyStimulus(1'b1, 20'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s1_req_drop", 32'(sdram_req), 32'd0);
        applyStimulus(1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 32'h0BADF00D);
        tick();
        checkOk("s1_nodst_ok", 1'b0);
        applyStimulus(1'b1, 20'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s1_wait_ok", 1'b0);
        checkOutput("s1_wait_req", 32'(sdram_req), 32'd0);
        applyStimulus(1'b1, 20'h10, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        tick();
        checkOk("s1_fill_ok", 1'b0);
        applyStimulus(1'b1, 20'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s1_hit_ok", 1'b1);
        checkOutput("s1_hit_dout", slot_dout, 32'hDEADBEEF);
        tick();
        checkOk("s1_hit_ok2", 1'b1);
        checkOutput("s1_hit_req", 32'(sdram_req), 32'd0);

        // Second entry, then table of hits alternating between the cached words
        doFetch(20'h11, 32'hCAFE0011);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].addr, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            checkOk($sformatf("vec%0d_ok", i), vecs[i].expOk);
            checkOutput($sformatf("vec%0d_dout", i), slot_dout, vecs[i].expDout);
            checkOutput($sformatf("vec%0d_req", i), 32'(sdram_req), 32'd0);
        end
`ifdef JTEXTERM_ROMSLOT_STATS_EN
        checkOutput("stats_miss", 32'(miss_cnt), 32'(expMiss));
        checkOutput("stats_hit", 32'(hit_cnt), 32'(expHits));
`endif

        // Third address evicts entry 0 (0x10); 0x11 still hits, 0x10 misses again
        doFetch(20'h12, 32'h12121212);
        applyStimulus(1'b1, 20'h11, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s3_11_ok", 1'b1);
        checkOutput("s3_11_dout", slot_dout, 32'hCAFE0011);
        checkOutput("s3_11_req", 32'(sdram_req), 32'd0);
        doFetch(20'h10, 32'hDEADBEEF);

        // Address moves on during WAIT: old fetch completes, new one follows
        applyStimulus(1'b1, 20'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s4_req20", 32'(sdram_req), 32'd1);
        checkOutput("s4_addr20", 32'(sdram_addr), 32'h40);
        applyStimulus(1'b1, 20'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 20'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s4_wait_req", 32'(sdram_req), 32'd0);
        checkOk("s4_wait_ok", 1'b0);
        applyStimulus(1'b1, 20'h30, 1'b0, 1'b1, 1'b1, 32'h20202020);
        tick();
        checkOutput("s4_fill_req", 32'(sdram_req), 32'd0);
        checkOk("s4_fill_ok", 1'b0);
        applyStimulus(1'b1, 20'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s4_req30", 32'(sdram_req), 32'd1);
        checkOutput("s4_addr30", 32'(sdram_addr), 32'h60);
        checkOk("s4_ok30_miss", 1'b0);
        applyStimulus(1'b1, 20'h30, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 20'h30, 1'b0, 1'b1, 1'b1, 32'h30303030);
        tick();
        checkOk("s4_fill30_ok", 1'b0);
        applyStimulus(1'b1, 20'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s4_hit30_ok", 1'b1);
        checkOutput("s4_hit30_dout", slot_dout, 32'h30303030);
        applyStimulus(1'b1, 20'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s4_hit20_ok", 1'b1);
        checkOutput("s4_hit20_dout", slot_dout, 32'h20202020);
        checkOutput("s4_hit20_req", 32'(sdram_req), 32'd0);

        // Ack and data in the same cycle
        applyStimulus(1'b1, 20'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s5_req", 32'(sdram_req), 32'd1);
        checkOutput("s5_addr", 32'(sdram_addr), 32'h80);
        applyStimulus(1'b1, 20'h40, 1'b1, 1'b1, 1'b1, 32'h40404040);
        tick();
        checkOutput("s5_req_drop", 32'(sdram_req), 32'd0);
        checkOk("s5_fill_ok", 1'b0);
        applyStimulus(1'b1, 20'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s5_hit_ok", 1'b1);
        checkOutput("s5_hit_dout", slot_dout, 32'h40404040);
        checkOutput("s5_hit_req", 32'(sdram_req), 32'd0);

        // Reset during WAIT, late data must not fill
        applyStimulus(1'b1, 20'h50, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s6_req", 32'(sdram_req), 32'd1);
        checkOutput("s6_addr", 32'(sdram_addr), 32'hA0);
        applyStimulus(1'b1, 20'h50, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 20'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOk("s6_wait_hit_ok", 1'b1);
        checkOutput("s6_wait_hit_dout", slot_dout, 32'h40404040);
        rst = 1'b1;
        #1;
        checkOutput("s6_rst_ok", 32'(slot_ok), 32'd0);
        checkOutput("s6_rst_req", 32'(sdram_req), 32'd0);
        checkOutput("s6_rst_dout", slot_dout, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 20'h50, 1'b0, 1'b1, 1'b1, 32'h50505050);
        tick();
        checkOutput("s6_late_req", 32'(sdram_req), 32'd0);
        applyStimulus(1'b1, 20'h50, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("s6_refetch_req", 32'(sdram_req), 32'd1);
        checkOutput("s6_refetch_addr", 32'(sdram_addr), 32'hA0);
        checkOk("s6_refetch_ok", 1'b0);

        applyStimulus(1'b0, 20'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
